rib_rr: RTL

- Parametrised, registered successor to the core's fixed 4-master/6-slave bus interconnect.
- Supports NM masters and NS slaves with round-robin arbitration.
- Each grant is held for a full request/acknowledge transaction; slaves may stall.
- Unmapped addresses and slave timeouts get an error response. Pipeline hold to the core is generated from a configurable master mask.

---
 rtl/rib_rr.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/rib_rr.sv
// rib_rr: registered round-robin bus interconnect, NM masters to NS slaves.
// Ports: clk, rst (async active-low); master side m_req_i/m_we_i/m_addr_i/
//   m_data_i in, m_data_o/m_ack_o/m_err_o out; slave side s_req_o/s_we_o/
//   s_addr_o/s_data_o out, s_data_i/s_ack_i in; grant_o, hold_flag_o status.
module rib_rr #(
    parameter int NM     = 4,
    parameter int NS     = 6,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RW     = 4,
    parameter int TO_CYC = 255,
    parameter logic [NM-1:0] HOLD_MASK = NM'(4'b1101)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NM-1:0]           m_req_i,
    input  logic [NM-1:0]           m_we_i,
    input  logic [NM*AW-1:0]        m_addr_i,
    input  logic [NM*DW-1:0]        m_data_i,
    output logic [NM*DW-1:0]        m_data_o,
    output logic [NM-1:0]           m_ack_o,
    output logic [NM-1:0]           m_err_o,
    output logic [NS-1:0]           s_req_o,
    output logic                    s_we_o,
    output logic [AW-1:0]           s_addr_o,
    output logic [DW-1:0]           s_data_o,
    input  logic [NS*DW-1:0]        s_data_i,
    input  logic [NS-1:0]           s_ack_i,
    output logic [$clog2(NM)-1:0]   grant_o,
    output logic                    hold_flag_o
);

    localparam int GW = $clog2(NM);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, rr_ptr_q, pick;
    logic             found;
    logic             we_q;
    logic [AW-RW-1:0] addr_q;
    logic [DW-1:0]    wdata_q, rdata_q;
    logic             err_q;
    logic [RW-1:0]    sel_q;
    logic [15:0]      cnt_q;

    logic             pick_we;
    logic [AW-1:0]    pick_addr;
    logic [DW-1:0]    pick_data;
    logic [RW-1:0]    region;
    logic             dec_ok;
    logic             ack_sel;
    logic [DW-1:0]    rdata_sel;
    logic             timeout;

    // First requester at or above rr_ptr, wrapping modulo NM.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NM; i++) begin
            if (!found && m_req_i[GW'((int'(rr_ptr_q) + i) % NM)]) begin
                found = 1'b1;
                pick  = GW'((int'(rr_ptr_q) + i) % NM);
            end
        end
    end

    always_comb begin
        pick_we   = 1'b0;
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NM; i++) begin
            if (GW'(i) == pick) begin
                pick_we   = m_we_i[i];
                pick_addr = m_addr_i[i*AW +: AW];
                pick_data = m_data_i[i*DW +: DW];
            end
        end
        region = pick_addr[AW-1 -: RW];
        dec_ok = int'(region) < NS;
    end

    // Only the selected slave's ack/data matter.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int j = 0; j < NS; j++) begin
            if (RW'(j) == sel_q) begin
                ack_sel   = s_ack_i[j];
                rdata_sel = s_data_i[j*DW +: DW];
            end
        end
        timeout = (cnt_q == 16'(TO_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = dec_ok ? BUSY : RESP;
            BUSY:    if (ack_sel || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (found) begin
                        grant_q <= pick;
                        we_q    <= pick_we;
                        addr_q  <= pick_addr[AW-RW-1:0];
                        wdata_q <= pick_data;
                        sel_q   <= region;
                        err_q   <= !dec_ok;
                        rdata_q <= '0;
                    end
                end
                BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (ack_sel) begin
                        rdata_q <= we_q ? '0 : rdata_sel;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RESP: begin
                    rr_ptr_q <= (int'(grant_q) == NM - 1) ? '0 : grant_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_ack_o  = '0;
        m_err_o  = '0;
        m_data_o = '0;
        if (state_q == RESP) begin
            for (int i = 0; i < NM; i++) begin
                if (GW'(i) == grant_q) begin
                    m_ack_o[i]            = 1'b1;
                    m_err_o[i]            = err_q;
                    m_data_o[i*DW +: DW]  = rdata_q;
                end
            end
        end
    end

    assign s_req_o  = (state_q == BUSY) ? (NS'(1) << sel_q) : '0;
    assign s_we_o   = (state_q == BUSY) && we_q;
    assign s_addr_o = (state_q == BUSY) ? {{RW{1'b0}}, addr_q} : '0;
    assign s_data_o = (state_q == BUSY) ? wdata_q : '0;
    assign grant_o  = grant_q;

    assign hold_flag_o = (|(m_req_i & HOLD_MASK)) ||
                         ((state_q != IDLE) && HOLD_MASK[grant_q]);

endmodule
